// File: rtl/forward_scoreboard_if.sv
// Operand-forwarding scoreboard bus: issue info, source addresses, forward selects and hazard stall.
interface forward_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned SEL_W      = 2
);
    localparam int unsigned CNT_W = 16;

    logic                           issue_valid;
    logic                           issue_regwrite;
    logic                           issue_is_load;
    logic [REG_ADDR_W-1:0]          issue_wreg;
    logic [NUM_READ*REG_ADDR_W-1:0] rd_addr;
    logic                           stall_in;
    logic                           flush;
    logic [NUM_READ*SEL_W-1:0]      fwd_sel;
    logic                           stall;
    logic [CNT_W-1:0]               stall_cnt;

    modport master (
        output issue_valid, issue_regwrite, issue_is_load, issue_wreg,
        output rd_addr, stall_in, flush,
        input  fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_regwrite, issue_is_load, issue_wreg,
        input  rd_addr, stall_in, flush,
        output fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/forward_scoreboard.sv
// Operand-forwarding and load-use hazard unit tracking DEPTH in-flight destinations.
// Optional stall-cycle counter enabled by defining FORWARD_SCOREBOARD_STALL_CNT_EN.
module forward_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    forward_scoreboard_if.slave  bus
);
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] wreg;
    } entry_t;

    entry_t                    entries [1:DEPTH];
    logic [NUM_READ-1:0]       hazard_c;
    logic [NUM_READ*SEL_W-1:0] fwd_sel_c;
    logic                      stall_c;

    // Youngest matching producer wins: scan oldest to youngest, later hits overwrite.
    always_comb begin : fwd_select
        logic [SEL_W-1:0]      sel;
        logic                  haz;
        logic [REG_ADDR_W-1:0] rd;
        fwd_sel_c = '0;
        hazard_c  = '0;
        sel       = '0;
        haz       = 1'b0;
        rd        = '0;
        for (int p = 0; p < int'(NUM_READ); p++) begin
            sel = '0;
            haz = 1'b0;
            rd  = bus.rd_addr[p*int'(REG_ADDR_W) +: REG_ADDR_W];
            for (int i = int'(DEPTH); i >= 1; i--) begin
                if (entries[i].valid && entries[i].regwrite &&
                    (entries[i].wreg != '0) && (entries[i].wreg == rd)) begin
                    sel = SEL_W'(i);
                    haz = entries[i].is_load && (i < int'(LOAD_READY));
                end
            end
            // Load data not yet available: the operand must wait, not forward.
            if (haz) begin
                sel = '0;
            end
            fwd_sel_c[p*int'(SEL_W) +: SEL_W] = sel;
            hazard_c[p]                       = haz;
        end
    end

    assign stall_c     = (|hazard_c) && !bus.stall_in;
    assign bus.fwd_sel = fwd_sel_c;
    assign bus.stall   = stall_c;

    // In-flight tracking shift register; entry 1 is the instruction now in EX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i <= int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else if (bus.stall_in) begin
            if (bus.flush) begin
                entries[1] <= '0;
            end
        end else begin
            for (int i = int'(DEPTH); i >= 2; i--) begin
                entries[i] <= entries[i-1];
            end
            if (stall_c || bus.flush || !bus.issue_valid) begin
                entries[1] <= '0;
            end else begin
                entries[1] <= '{valid:    1'b1,
                                regwrite: bus.issue_regwrite,
                                is_load:  bus.issue_is_load,
                                wreg:     bus.issue_wreg};
            end
        end
    end

`ifdef FORWARD_SCOREBOARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of hazard stall cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed self-checking bench for forward_scoreboard (default parameters).
module tb_forward_scoreboard;
    logic clk;
    logic reset;
    int   total;
    int   bad;

`ifdef FORWARD_SCOREBOARD_STALL_CNT_EN
    localparam logic [15:0] EXP_ONE = 16'd1;
`else
    localparam logic [15:0] EXP_ONE = 16'd0;
`endif

    forward_scoreboard_if #(.REG_ADDR_W(5), .NUM_READ(2), .SEL_W(2)) bus ();

    forward_scoreboard #(
        .REG_ADDR_W(5), .DEPTH(3), .NUM_READ(2), .LOAD_READY(2), .SEL_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic rw, input logic ld,
                         input logic [4:0] w, input logic [4:0] a0, input logic [4:0] a1);
        bus.issue_valid    = v;
        bus.issue_regwrite = rw;
        bus.issue_is_load  = ld;
        bus.issue_wreg     = w;
        bus.rd_addr        = {a1, a0};
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd1);
        #3;
        total++; if (bus.fwd_sel !== 4'h0) begin bad++; $display("FAIL reset_fwd: got %h want %h", bus.fwd_sel, 4'h0); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %h want 0", bus.stall_cnt); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_alu_chain();
        do_reset();
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0); #1;
        total++; if (bus.fwd_sel !== 4'h1) begin bad++; $display("FAIL alu_stage1: got %h want %h", bus.fwd_sel, 4'h1); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b want 0", bus.stall); end
        @(negedge clk); #1;
        total++; if (bus.fwd_sel !== 4'h2) begin bad++; $display("FAIL alu_stage2: got %h want %h", bus.fwd_sel, 4'h2); end
        @(negedge clk); #1;
        total++; if (bus.fwd_sel !== 4'h3) begin bad++; $display("FAIL alu_stage3: got %h want %h", bus.fwd_sel, 4'h3); end
        @(negedge clk); #1;
        total++; if (bus.fwd_sel !== 4'h0) begin bad++; $display("FAIL alu_dropped: got %h want %h", bus.fwd_sel, 4'h0); end
    endtask

    task automatic test_priority();
        do_reset();
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7); #1;
        total++; if (bus.fwd_sel !== 4'h5) begin bad++; $display("FAIL priority_fwd: got %h want %h", bus.fwd_sel, 4'h5); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL priority_stall: got %b want 0", bus.stall); end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd3, 5'd0); #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
        total++; if (bus.fwd_sel !== 4'h0) begin bad++; $display("FAIL lu_fwd_zero: got %h want %h", bus.fwd_sel, 4'h0); end
        @(negedge clk); #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_release: got %b want 0", bus.stall); end
        total++; if (bus.fwd_sel !== 4'h2) begin bad++; $display("FAIL lu_fwd_stage2: got %h want %h", bus.fwd_sel, 4'h2); end
        total++; if (bus.stall_cnt !== EXP_ONE) begin bad++; $display("FAIL lu_cnt: got %h want %h", bus.stall_cnt, EXP_ONE); end
        // One unrelated instruction between load and consumer: no stall.
        do_reset();
        @(negedge clk); drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0); #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_gap_stall: got %b want 0", bus.stall); end
        total++; if (bus.fwd_sel !== 4'h2) begin bad++; $display("FAIL lu_gap_fwd: got %h want %h", bus.fwd_sel, 4'h2); end
    endtask

    task automatic test_r0_nowrite();
        do_reset();
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 5'd0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4); #1;
        total++; if (bus.fwd_sel !== 4'h0) begin bad++; $display("FAIL r0_nowrite_fwd: got %h want %h", bus.fwd_sel, 4'h0); end
    endtask

    task automatic test_freeze_flush();
        do_reset();
        @(negedge clk); drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd3, 5'd0);
        bus.stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL freeze_stall%0d: got %b want 0", k, bus.stall); end
            total++; if (bus.fwd_sel !== 4'h0) begin bad++; $display("FAIL freeze_fwd%0d: got %h want %h", k, bus.fwd_sel, 4'h0); end
            @(negedge clk);
        end
        bus.stall_in = 1'b0; #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL freeze_held: got %b want 1", bus.stall); end
        total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL freeze_cnt: got %h want 0", bus.stall_cnt); end
        @(negedge clk); bus.flush = 1'b1; drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd3, 5'd0); #1;
        total++; if (bus.fwd_sel !== 4'h2) begin bad++; $display("FAIL flush_pre_fwd: got %h want %h", bus.fwd_sel, 4'h2); end
        @(negedge clk); bus.flush = 1'b0; drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd8, 5'd3); #1;
        total++; if (bus.fwd_sel !== 4'hC) begin bad++; $display("FAIL flush_bubble: got %h want %h", bus.fwd_sel, 4'hC); end
        total++; if (bus.stall_cnt !== EXP_ONE) begin bad++; $display("FAIL flush_cnt: got %h want %h", bus.stall_cnt, EXP_ONE); end
        // Flush while frozen clears entry 1.
        do_reset();
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0);
        bus.stall_in = 1'b1; bus.flush = 1'b1; #1;
        total++; if (bus.fwd_sel !== 4'h1) begin bad++; $display("FAIL frozen_flush_pre: got %h want %h", bus.fwd_sel, 4'h1); end
        @(negedge clk); bus.stall_in = 1'b0; bus.flush = 1'b0; #1;
        total++; if (bus.fwd_sel !== 4'h0) begin bad++; $display("FAIL frozen_flush_post: got %h want %h", bus.fwd_sel, 4'h0); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        @(negedge clk); drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd11, 5'd3, 5'd0);
        @(negedge clk);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd12, 5'd0, 5'd0);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5'd13, 5'd0, 5'd0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd13, 5'd11); #1;
        total++; if (bus.fwd_sel !== 4'hD) begin bad++; $display("FAIL midrun_fwd: got %h want %h", bus.fwd_sel, 4'hD); end
        total++; if (bus.stall_cnt !== EXP_ONE) begin bad++; $display("FAIL midrun_cnt: got %h want %h", bus.stall_cnt, EXP_ONE); end
        #1 reset = 1'b0; #1;
        total++; if (bus.fwd_sel !== 4'h0) begin bad++; $display("FAIL midrun_rst_fwd: got %h want %h", bus.fwd_sel, 4'h0); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL midrun_rst_stall: got %b want 0", bus.stall); end
        total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL midrun_rst_cnt: got %h want 0", bus.stall_cnt); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        total++; if (bus.fwd_sel !== 4'h0) begin bad++; $display("FAIL post_rst_fwd: got %h want %h", bus.fwd_sel, 4'h0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu_chain();
        test_priority();
        test_load_use();
        test_r0_nowrite();
        test_freeze_flush();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised operand-forwarding and load-use hazard unit for the pipelined CPU. Tracks destination registers of up to DEPTH in-flight instructions in an internal shift register, and returns a per-port forward select for NUM_READ decode-stage source operands. Raises a stall when an operand depends on a load whose data is not yet available. Sits beside the ID stage and drives the operand muxes and the pipeline-register enables.

## Interface
- REG_ADDR_W, 5: register address width.
- DEPTH, 3: tracked in-flight stages; stage 1 = ID/EX, stage DEPTH = oldest.
- NUM_READ, 2: number of source-operand ports.
- LOAD_READY, 2: first stage at which load data is forwardable (1 ≤ LOAD_READY ≤ DEPTH).
- SEL_W, 2: forward-select width; must satisfy 2^SEL_W ≥ DEPTH+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  an instruction leaves ID this cycle.
- issue_regwrite  in  1  issuing instruction writes a register.
- issue_is_load  in  1  issuing instruction is a load.
- issue_wreg  in  REG_ADDR_W  destination of the issuing instruction.
- rd_addr  in  NUM_READ*REG_ADDR_W  source addresses; port p at bits [p*REG_ADDR_W +: REG_ADDR_W].
- stall_in  in  1  external freeze of the whole pipeline.
- flush  in  1  squash the issuing instruction.
- fwd_sel  out  NUM_READ*SEL_W  per port: 0 = register file, k = forward from stage k.
- stall  out  1  load-use hazard; hold IF/ID and insert a bubble.
- stall_cnt  out  16  hazard stall cycle count (see Configuration).

## Operation
- Entry i (1..DEPTH) holds {valid, regwrite, is_load, wreg}. Reset clears all entries.
- Match on port p, stage i: valid & regwrite & wreg ≠ 0 & wreg == rd_addr[p]. Register 0 never matches.
- Priority: the lowest matching stage wins (youngest producer). No match gives fwd_sel = 0.
- Hazard on port p: the winning entry has is_load=1 and i < LOAD_READY. Then fwd_sel[p] = 0.
- stall = OR of all port hazards, gated to 0 while stall_in=1.
- Update on each rising clk edge, in priority order:
  - stall_in=1: all entries hold. If flush=1, entry 1 is also cleared.
  - Otherwise, entries shift: entry i+1 ← entry i, and the oldest entry is dropped.
  - Entry 1 gets a bubble (valid=0) if stall=1, flush=1, or issue_valid=0.
  - Otherwise entry 1 gets {1, issue_regwrite, issue_is_load, issue_wreg}.
- Multiple ports may forward from the same stage.
- A port with no match reads the register file even if an older entry exists with regwrite=0.

## Timing
- fwd_sel and stall are combinational from the current entries and rd_addr, and are valid in the same cycle as ID.
- An issued instruction is visible as stage 1 on the next cycle, and as stage k after k cycles of non-frozen pipeline.
- Load-use with LOAD_READY=2: exactly 1 stall cycle for a dependent instruction that immediately follows the load. No stall if one unrelated instruction lies between them.
- Reset is asynchronous and clears immediately. Outputs read as: fwd_sel=0, stall=0, stall_cnt=0, all entries invalid.
- Reset mid-operation discards all in-flight tracking. The first post-reset instructions never forward.

## Configuration
- Macro: FORWARD_SCOREBOARD_STALL_CNT_EN.
- Defined: stall_cnt is a 16-bit counter. It increments on every clk edge where stall=1, saturates at 16'hFFFF, and is cleared only by reset.
- Undefined: no counter logic is built and stall_cnt is tied to 16'h0000. All other behaviour is identical.

## Test plan
- ALU chain: issue wreg=5, then read rd_addr[0]=5 next cycle. Expect fwd_sel[0]=1. One cycle later, without a new match, expect 2.
- Priority: stage 1 and stage 2 both write r7, and port 1 reads r7. Expect fwd_sel[1]=1, stall=0.
- Load-use: issue a load to r3, then next cycle read r3. Expect stall=1 and fwd_sel=0 for one cycle. Entry 1 becomes a bubble, and the following cycle gives fwd_sel=2 with stall=0.
- r0 / no-write: issue wreg=0 with regwrite=1, and separately wreg=4 with regwrite=0. Reads of r0 and r4 return fwd_sel=0.
- Freeze/flush: a load hazard is pending and stall_in=1 is held for 3 cycles. Expect stall=0, entries held, and stall_cnt unchanged. Then flush=1 with issue_valid=1 gives a bubble in entry 1.
- Reset mid-run: with 3 valid entries, assert reset low. Expect all outputs 0 immediately, and stall_cnt=0 (with the macro defined, counter previously nonzero).
